// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use interlock, taken-branch
// flush and a data-memory req/ready handshake with an optional timeout.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              branch_taken_i,
  input  logic              mem_access_i,
  input  logic              dmem_ready_i,
  output logic              dmem_req_o,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              idex_we_o,
  output logic              exmem_we_o,
  output logic              memwb_bubble_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

  state_t             state_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;

  logic load_use;
  logic freeze;
  logic timeout_hit;

  assign load_use = ex_memread_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  assign freeze = ((state_reg == RUN) && mem_access_i && !dmem_ready_i) ||
                  ((state_reg == MEM_WAIT) && !dmem_ready_i) ||
                  (state_reg == MEM_ERR);

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_W'(TO_LAST));

  // The ready cycle of MEM_WAIT falls through to the hazard checks, so a
  // load-use or branch held off by the freeze is honoured as the pipe moves.
  always_comb begin
    pc_we_o        = 1'b1;
    ifid_we_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    idex_we_o      = 1'b1;
    exmem_we_o     = 1'b1;
    memwb_bubble_o = 1'b0;
    case (state_reg)
      RUN:      dmem_req_o = mem_access_i;
      MEM_WAIT: dmem_req_o = 1'b1;
      default:  dmem_req_o = 1'b0;
    endcase

    if (freeze) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      idex_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (load_use) begin
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end

    if (!rst_i) begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      idex_we_o      = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b1;
      dmem_req_o     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      if (!pc_we_o && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;

      case (state_reg)
        RUN: begin
          if (mem_access_i && !dmem_ready_i) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            state_reg <= MEM_ERR;
            err_reg   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= MEM_ERR;
          err_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign err_o       = err_reg;
  assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. It drives write-enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses through a req/ready handshake with timeout.
- Sits beside the pipeline registers and is the only source of their enable/bubble inputs.

Parameters:
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before error; 0 disables the timeout.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-low reset.
- id_rs1_i  in  REG_AW  rs1 of the instruction in ID.
- id_rs2_i  in  REG_AW  rs2 of the instruction in ID.
- ex_memread_i  in  1  the instruction in EX is a load.
- ex_rd_i  in  REG_AW  rd of the instruction in EX.
- branch_taken_i  in  1  branch resolved taken in ID.
- mem_access_i  in  1  the instruction in MEM is a load or store.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- dmem_req_o  out  1  data memory request.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_bubble_o  out  1  ID/EX loads control zeros.
- idex_we_o  out  1  ID/EX write enable.
- exmem_we_o  out  1  EX/MEM write enable.
- memwb_bubble_o  out  1  MEM/WB loads RegWrite=0 and MemReg=0.
- err_o  out  1  sticky memory timeout flag.
- stall_cnt_o  out  CNT_W  count of cycles with pc_we_o=0.

Behaviour:
- **States:** RUN, MEM_WAIT, MEM_ERR. The state and wait counter are registered; all control outputs are combinational from state and inputs.
- **Reset:** rst_i=0 at a rising edge sets state=RUN, wait_cnt=0, err_o=0 and stall_cnt_o=0. While rst_i=0 all outputs are forced:
  - all *_we_o = 0;
  - idex_bubble_o = 1, memwb_bubble_o = 1;
  - ifid_flush_o = 0, dmem_req_o = 0.
- **Reset mid-MEM_WAIT:** aborts the access; dmem_req_o drops in the same cycle.
- **Defaults in RUN:** all *_we_o = 1; bubbles, flush and dmem_req_o = 0.
- **Memory in RUN:** dmem_req_o = mem_access_i.
  - If mem_access_i=1 and dmem_ready_i=1: zero-stall completion; state stays RUN.
  - If mem_access_i=1 and dmem_ready_i=0: go to MEM_WAIT next cycle, and this cycle applies the freeze below.
- **Freeze:** pc_we, ifid_we, idex_we and exmem_we are all 0; memwb_bubble_o = 1; load-use and branch outputs are suppressed.
- **MEM_WAIT:** dmem_req_o held 1 and the freeze applies.
  - If dmem_ready_i=1: release all enables that cycle (memwb_bubble_o=0, so MEM/WB captures the data); go to RUN; wait_cnt=0.
  - Else wait_cnt increments.
  - If MEM_TIMEOUT≠0 and wait_cnt reaches MEM_TIMEOUT-1 without ready: go to MEM_ERR.
- **Load-use (RUN, no memory stall):** a hazard exists when ex_memread_i=1, ex_rd_i≠0 and ex_rd_i equals id_rs1_i or id_rs2_i.
  - Response: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1; downstream enables stay 1.
  - Lasts exactly one cycle because the load advances.
- **Branch (RUN, no memory stall, no load-use):** branch_taken_i=1 gives ifid_flush_o=1 for one cycle; PC updates normally.
- **Priority:** memory stall > load-use > branch. A suppressed branch is re-evaluated when the stall releases.
- **MEM_ERR:** err_o=1; freeze outputs; dmem_req_o=0. Exits only by reset.
- **stall_cnt_o:** increments on every non-reset cycle with pc_we_o=0 and saturates at all-ones.

Test Plan:
- **Reset:** hold rst_i=0 for 2 cycles with mem_access_i=1 → dmem_req_o=0, all we=0, bubbles=1, stall_cnt_o=0, err_o=0.
- **Load-use:** ex_memread_i=1, ex_rd_i=5, id_rs2_i=5 → exactly one cycle of pc_we_o=0, ifid_we_o=0, idex_bubble_o=1; stall_cnt_o becomes 1.
- **Load into x0:** repeat with ex_rd_i=0, id_rs1_i=0 → no stall. Then ex_rd_i=5, id_rs1_i=5 with branch_taken_i=1 → stall asserted, ifid_flush_o=0.
- **3-cycle memory wait:** mem_access_i=1, dmem_ready_i low for 3 cycles then high → dmem_req_o high for 4 cycles; memwb_bubble_o=1 for 3 cycles; all we=1 on the ready cycle; state back to RUN; stall_cnt_o=3.
- **Timeout:** MEM_TIMEOUT=4, dmem_ready_i never asserted → err_o=1 after the 4th MEM_WAIT cycle; dmem_req_o=0; enables stay 0; rst_i=0 clears err_o.
- **Reset mid-wait:** assert rst_i=0 during MEM_WAIT, then release with mem_access_i=0 → state RUN, all we=1 on the first cycle after reset.
